// File: rtl/axis_seq_pkg.sv
// axis_seq_pkg: shared types for the AXI-Stream burst sequencer.
// Holds the sequencer state encoding and the default counter width.
package axis_seq_pkg;

  localparam int LEN_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/axis_seq_gap_timer.sv
// axis_seq_gap_timer: loadable down-counter timing inter-burst gaps.
// Ports: clk, rst (sync, active-high), load/load_val, dec, tc (count==1).
module axis_seq_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // tc at count 1 lets the FSM leave on the following edge,
  // giving exactly load_val idle cycles.
  assign tc = (cnt == W'(1));

endmodule

// File: rtl/axis_testpattern_burst_sequencer.sv
// axis_testpattern_burst_sequencer: frames a pattern generator into
// bursts of N beats, M idle cycles apart, K bursts per run (0 = forever).
// Ports: m_axis_aclk, m_axis_areset (sync, high); start/stop pulses;
// cfg_burst_len/cfg_gap_cycles/cfg_num_bursts; gen_enable; s_axis_*
// from generator; m_axis_* to consumer; busy, done, burst_cnt status.
// Build option AXIS_SEQ_SOF_TUSER_EN adds m_axis_tuser (start of burst).
module axis_testpattern_burst_sequencer
  import axis_seq_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_areset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LEN_WIDTH-1:0]   cfg_burst_len,
  input  logic [LEN_WIDTH-1:0]   cfg_gap_cycles,
  input  logic [LEN_WIDTH-1:0]   cfg_num_bursts,
  output logic                   gen_enable,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   burst_cnt
`ifdef AXIS_SEQ_SOF_TUSER_EN
  ,
  output logic                   m_axis_tuser
`endif
);

  seq_state_t           state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] gap_q;
  logic [LEN_WIDTH-1:0] num_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] bursts_next;
  logic                 stop_pending;
  logic                 run;
  logic                 hs;
  logic                 last_beat;
  logic                 run_end;
  logic                 gap_load;
  logic                 gap_tc;

  assign run = (state == ST_RUN);

  // Zero-latency pass-through, gated by state.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = run & s_axis_tvalid;
  assign s_axis_tready = run & m_axis_tready;
  assign gen_enable    = run;

  assign hs           = m_axis_tvalid & m_axis_tready;
  assign last_beat    = (beat_cnt == len_q - LEN_WIDTH'(1));
  assign m_axis_tlast = last_beat & m_axis_tvalid;
  assign bursts_next  = burst_cnt + LEN_WIDTH'(1);

  // A stop arriving with the last beat counts as already pending.
  assign run_end = stop_pending | stop |
                   ((num_q != '0) && (bursts_next == num_q));

  assign gap_load = hs & last_beat & ~run_end & (gap_q != '0);

`ifdef AXIS_SEQ_SOF_TUSER_EN
  assign m_axis_tuser = m_axis_tvalid & (beat_cnt == '0);
`endif

  axis_seq_gap_timer #(
    .W (LEN_WIDTH)
  ) u_gap (
    .clk      (m_axis_aclk),
    .rst      (m_axis_areset),
    .load     (gap_load),
    .load_val (gap_q),
    .dec      (state == ST_GAP),
    .tc       (gap_tc)
  );

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state        <= ST_IDLE;
      len_q        <= LEN_WIDTH'(1);
      gap_q        <= '0;
      num_q        <= '0;
      beat_cnt     <= '0;
      burst_cnt    <= '0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len_q        <= (cfg_burst_len == '0) ?
                            LEN_WIDTH'(1) : cfg_burst_len;
            gap_q        <= cfg_gap_cycles;
            num_q        <= cfg_num_bursts;
            beat_cnt     <= '0;
            burst_cnt    <= '0;
            stop_pending <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (hs) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              burst_cnt <= bursts_next;
              if (run_end) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else if (gap_q != '0) begin
                state <= ST_GAP;
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (gap_tc) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy         <= 1'b0;
          stop_pending <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_testpattern_burst_sequencer.sv
// tb_axis_testpattern_burst_sequencer: directed self-checking bench.
// Counting generator source, scripted consumer ready, stop and start.
module tb_axis_testpattern_burst_sequencer;

  localparam int TW = 32;
  localparam int LW = 16;

  logic          m_axis_aclk;
  logic          m_axis_areset;
  logic          start;
  logic          stop;
  logic [LW-1:0] cfg_burst_len;
  logic [LW-1:0] cfg_gap_cycles;
  logic [LW-1:0] cfg_num_bursts;
  logic          gen_enable;
  logic [TW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [LW-1:0] burst_cnt;
`ifdef AXIS_SEQ_SOF_TUSER_EN
  logic          m_axis_tuser;
`endif

  int            nvec;
  int            nerr;
  logic [TW-1:0] gen_data;
  logic [TW-1:0] base;
  logic [TW-1:0] beats[$];
  int            lmask;
  int            idle;
  int            done_cyc;

  axis_testpattern_burst_sequencer #(
    .TDATA_WIDTH (TW),
    .LEN_WIDTH   (LW)
  ) dut (
    .m_axis_aclk    (m_axis_aclk),
    .m_axis_areset  (m_axis_areset),
    .start          (start),
    .stop           (stop),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_gap_cycles (cfg_gap_cycles),
    .cfg_num_bursts (cfg_num_bursts),
    .gen_enable     (gen_enable),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .done           (done),
    .burst_cnt      (burst_cnt)
`ifdef AXIS_SEQ_SOF_TUSER_EN
    ,
    .m_axis_tuser   (m_axis_tuser)
`endif
  );

  initial m_axis_aclk = 1'b0;
  always #5 m_axis_aclk = ~m_axis_aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; generator advances on its own handshake.
  task automatic tick();
    logic hs;
    hs = s_axis_tvalid && s_axis_tready;
    @(posedge m_axis_aclk);
    @(negedge m_axis_aclk);
    if (hs) gen_data = gen_data + 1;
    s_axis_tdata = gen_data;
    #1;
  endtask

  task automatic do_start(input int len, input int gap, input int num);
    cfg_burst_len  = LW'(len);
    cfg_gap_cycles = LW'(gap);
    cfg_num_bursts = LW'(num);
    base  = gen_data;
    start = 1'b1;
    #1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic collect(input int budget, input int stop_beat,
                         input bit toggle, input int start_cyc);
    bit stop_sent;
    stop_sent = 1'b0;
    beats.delete();
    lmask    = 0;
    idle     = 0;
    done_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      m_axis_tready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (!stop_sent && stop_beat >= 0 && beats.size() == stop_beat &&
          m_axis_tvalid && m_axis_tready) begin
        stop      = 1'b1;
        stop_sent = 1'b1;
      end
      start = (c == start_cyc);
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_axis_tlast) lmask = lmask | (1 << beats.size());
        beats.push_back(m_axis_tdata);
      end
      if (busy && !done && !gen_enable) idle++;
      if (done) done_cyc = c;
      tick();
      stop  = 1'b0;
      start = 1'b0;
      if (done_cyc >= 0) break;
    end
    m_axis_tready = 1'b1;
    #1;
  endtask

  task automatic chk_data(input string tag);
    for (int i = 0; i < beats.size(); i++)
      chk(tag, beats[i], base + TW'(i));
  endtask

  initial begin
    nvec           = 0;
    nerr           = 0;
    m_axis_areset  = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    cfg_burst_len  = '0;
    cfg_gap_cycles = '0;
    cfg_num_bursts = '0;
    s_axis_tvalid  = 1'b1;
    m_axis_tready  = 1'b1;
    gen_data       = 32'h0000_1000;
    s_axis_tdata   = gen_data;
    @(negedge m_axis_aclk);
    tick();
    tick();
    chk("rst_outs", {gen_enable, s_axis_tready, m_axis_tvalid,
                     m_axis_tlast, busy, done}, 0);
    chk("rst_bcnt", burst_cnt, 0);
    m_axis_areset = 1'b0;
    stop = 1'b1;
    #1;
    tick();
    stop = 1'b0;
    chk("idle_stop", busy, 0);

    // 1: len 4, gap 0, two bursts back to back
    do_start(4, 0, 2);
    chk("t1_busy", busy, 1);
    collect(40, -1, 1'b0, -1);
    chk("t1_done", done_cyc, 8);
    chk("t1_nbeat", beats.size(), 8);
    chk("t1_last", lmask, 32'h88);
    chk("t1_idle", idle, 0);
    chk_data("t1_data");
    chk("t1_bcnt", burst_cnt, 2);
    chk("t1_busy0", busy, 0);
    chk("t1_done0", done, 0);

    // 2: len 3, gap 5, two bursts
    do_start(3, 5, 2);
    collect(40, -1, 1'b0, -1);
    chk("t2_done", done_cyc, 11);
    chk("t2_nbeat", beats.size(), 6);
    chk("t2_last", lmask, 32'h24);
    chk("t2_idle", idle, 5);
    chk_data("t2_data");
    chk("t2_bcnt", burst_cnt, 2);

    // 3: infinite run, stop on beat 2 of burst 3
    do_start(4, 0, 0);
    collect(60, 9, 1'b0, -1);
    chk("t3_done", done_cyc, 12);
    chk("t3_nbeat", beats.size(), 12);
    chk("t3_last", lmask, 32'h888);
    chk_data("t3_data");
    chk("t3_bcnt", burst_cnt, 3);

    // 4: consumer ready toggles every cycle
    do_start(4, 0, 1);
    collect(40, -1, 1'b1, -1);
    chk("t4_done", done_cyc, 7);
    chk("t4_nbeat", beats.size(), 4);
    chk("t4_last", lmask, 32'h8);
    chk_data("t4_data");
    chk("t4_bcnt", burst_cnt, 1);

    // 5: reset on beat 2 of a 4-beat burst
    do_start(4, 0, 1);
    tick();
    chk("t5_mid", {m_axis_tvalid, m_axis_tlast}, 2'b10);
    m_axis_areset = 1'b1;
    #1;
    tick();
    m_axis_areset = 1'b0;
    #1;
    chk("t5_outs", {gen_enable, s_axis_tready, m_axis_tvalid,
                    m_axis_tlast, busy, done}, 0);
    chk("t5_bcnt", burst_cnt, 0);
    do_start(2, 0, 1);
    collect(40, -1, 1'b0, -1);
    chk("t5_done", done_cyc, 2);
    chk("t5_last", lmask, 32'h2);
    chk_data("t5_data");
    chk("t5_bcnt2", burst_cnt, 1);

    // 6: len 0 acts as 1; start and cfg change while busy ignored
    do_start(0, 0, 1);
    cfg_burst_len  = LW'(5);
    cfg_num_bursts = LW'(3);
    collect(40, -1, 1'b0, 0);
    chk("t6_done", done_cyc, 1);
    chk("t6_nbeat", beats.size(), 1);
    chk("t6_last", lmask, 32'h1);
    chk_data("t6_data");
    tick();
    tick();
    chk("t6_busy", {busy, gen_enable, m_axis_tvalid}, 0);
    chk("t6_bcnt", burst_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axis_testpattern_burst_sequencer.md
Name: axis_testpattern_burst_sequencer

Overview:
Sequences an AXI-Stream test-pattern generator into framed bursts: N beats per burst, M idle cycles between bursts, K bursts per run (or free-running). Sits between the generator's master port and the downstream consumer. Passes tdata through, gates the handshake, adds tlast, and drives the generator's enable. Software starts and stops runs via pulse inputs and reads status.

Parameters:
TDATA_WIDTH, 32, width of pass-through tdata.
LEN_WIDTH, 16, width of the burst-length, gap and burst-count config/counters.

Ports:
m_axis_aclk  in  1  sole clock.
m_axis_areset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; latches config and begins a run.
stop  in  1  one-cycle pulse; graceful stop request.
cfg_burst_len  in  LEN_WIDTH  beats per burst (0 treated as 1).
cfg_gap_cycles  in  LEN_WIDTH  idle cycles between bursts (0 = back-to-back).
cfg_num_bursts  in  LEN_WIDTH  bursts per run (0 = infinite).
gen_enable  out  1  enable to the generator.
s_axis_tdata  in  TDATA_WIDTH  from generator.
s_axis_tvalid  in  1  from generator.
s_axis_tready  out  1  to generator.
m_axis_tdata  out  TDATA_WIDTH  to consumer.
m_axis_tvalid  out  1  to consumer.
m_axis_tready  in  1  from consumer.
m_axis_tlast  out  1  last beat of burst.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse at end of run.
burst_cnt  out  LEN_WIDTH  bursts completed in current/last run.

Behaviour:
- Reset: state IDLE; gen_enable, s_axis_tready, m_axis_tvalid, m_axis_tlast, busy and done are 0; burst_cnt, beat and gap counters are 0; stop_pending is cleared. Reset mid-burst aborts immediately, with no tlast emitted.
- States: IDLE, RUN, GAP, DONE.
- IDLE: on start, latch the three cfg inputs, clear burst_cnt and the beat counter, go to RUN, raise busy. stop in IDLE is ignored.
- RUN: combinational pass-through with zero latency:
  - m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, m_axis_tdata = s_axis_tdata.
  - gen_enable = 1.
  - beat_cnt increments on each m_axis handshake (tvalid & tready).
  - m_axis_tlast = (beat_cnt == len-1) & m_axis_tvalid.
- Last-beat handshake in RUN:
  - burst_cnt increments and beat_cnt clears.
  - Then, in priority order:
    1. stop_pending, or (num_bursts != 0 and burst_cnt+1 == num_bursts) -> DONE.
    2. gap == 0 -> stay in RUN.
    3. Otherwise load the gap counter with gap and go to GAP.
- GAP: m_axis_tvalid = 0, s_axis_tready = 0, gen_enable = 0. The counter decrements each cycle and the state moves to RUN the cycle after it reaches 1, so exactly cfg_gap_cycles idle cycles occur. stop in GAP -> DONE next cycle.
- stop in RUN: set stop_pending; the current burst completes with a proper tlast, then DONE. Bursts are never truncated.
- stop and last-beat handshake in the same cycle: treated as stop_pending -> DONE.
- DONE: single cycle; done = 1, all stream outputs deasserted, busy = 0 on the cycle after; return to IDLE.
- start while busy is ignored; config changes mid-run have no effect.
- Simultaneous start and stop in IDLE: start wins, and the stop is discarded.
- burst_cnt holds its final value in IDLE until the next start.
- No internal buffering. The sequencer never asserts m_axis_tvalid unless s_axis_tvalid is high. Outside RUN, generator data stalls via s_axis_tready = 0.

Optional Feature:
AXIS_SEQ_SOF_TUSER_EN:
- Defined: adds output m_axis_tuser (1 bit), high on the first beat of every burst (beat_cnt == 0 in RUN, qualified by tvalid), and 0 in reset and outside RUN.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package axis_seq_pkg holds the state enum (IDLE/RUN/GAP/DONE) and a LEN_WIDTH default constant.
- One natural sub-module, axis_seq_gap_timer: loadable down-counter with a terminal-count output, used for the GAP state.
- Beat counting stays inline in the top module.

Test Plan:
1. len=4, gap=0, num=2, tready=1, generator always valid -> 8 contiguous beats, tlast on beats 4 and 8, done pulse, then burst_cnt=2, busy=0.
2. len=3, gap=5, num=2 -> 3 beats, exactly 5 cycles with tvalid=0 and gen_enable=0, 3 beats; tlast on the 3rd and 6th.
3. len=4, num=0, stop pulsed on beat 2 of burst 3 -> beats 3 and 4 delivered, tlast on beat 4, done; burst_cnt=3.
4. Consumer tready toggling 1/0 every cycle, len=4, num=1 -> the 4 beats match the generator sequence in order, none lost or duplicated, tlast only on the 4th accepted beat.
5. Reset asserted mid-burst (beat 2 of 4) -> next cycle all outputs 0, state IDLE; a new start with len=2 yields a clean 2-beat burst.
6. len=0, num=1 -> a single beat with tlast; a start pulse while busy causes no restart and burst_cnt stays 1.
